// File: rtl/lsu_sequencer.sv
// Load/store sequencer: walks one LC-3 style memory instruction through CALC/PTR/DATA/FIN.
// Optional request timeout is enabled by defining LSU_TIMEOUT_EN.

module effective_address (
    input  logic [15:0] PC,
    input  logic [15:0] BASE,
    input  logic [10:0] OFFSET,
    input  logic [2:0]  CONTROL,
    output logic [15:0] EA
);
    logic [15:0] base_sel;
    logic [15:0] offset_ext;

    // CONTROL[0] picks RS1 over PC; CONTROL[2:1] picks offset width 0/9/6/11.
    always_comb begin
        base_sel = CONTROL[0] ? BASE : PC;
        case (CONTROL[2:1])
            2'b01:   offset_ext = {{7{OFFSET[8]}}, OFFSET[8:0]};
            2'b10:   offset_ext = {{10{OFFSET[5]}}, OFFSET[5:0]};
            2'b11:   offset_ext = {{5{OFFSET[10]}}, OFFSET[10:0]};
            default: offset_ext = 16'h0000;
        endcase
        EA = base_sel + offset_ext;
    end
endmodule

module lsu_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [15:0] IR,
    input  logic [15:0] PC,
    input  logic [15:0] RS1_DATA,
    input  logic [15:0] SR_DATA,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    input  logic [15:0] MEM_RDATA,
    input  logic        MEM_READY,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        REG_WE,
    output logic [2:0]  REG_DR,
    output logic [15:0] REG_DATA
);
    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StCalc = 3'd1;
    localparam logic [2:0] StPtr  = 3'd2;
    localparam logic [2:0] StData = 3'd3;
    localparam logic [2:0] StFin  = 3'd4;

    localparam logic [3:0] OpLd  = 4'b0010;
    localparam logic [3:0] OpSt  = 4'b0011;
    localparam logic [3:0] OpLdr = 4'b0110;
    localparam logic [3:0] OpStr = 4'b0111;
    localparam logic [3:0] OpLdi = 4'b1010;
    localparam logic [3:0] OpSti = 4'b1011;
    localparam logic [3:0] OpLea = 4'b1110;

    logic [2:0]  state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] rs1_q, rs1_d;
    logic [15:0] sr_q, sr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;

    logic [3:0]  opcode;
    logic        is_load, is_store, is_ind, is_lea, is_reg_base, supported;
    logic [2:0]  ea_control;
    logic [15:0] ea;
    logic        timeout_hit;

    assign opcode      = ir_q[15:12];
    assign is_load     = (opcode == OpLd) || (opcode == OpLdr) || (opcode == OpLdi);
    assign is_store    = (opcode == OpSt) || (opcode == OpStr) || (opcode == OpSti);
    assign is_ind      = (opcode == OpLdi) || (opcode == OpSti);
    assign is_lea      = (opcode == OpLea);
    assign is_reg_base = (opcode == OpLdr) || (opcode == OpStr);
    assign supported   = is_load || is_store || is_lea;
    assign ea_control  = is_reg_base ? 3'b101 : 3'b010;

    effective_address u_ea (
        .PC      (pc_q),
        .BASE    (rs1_q),
        .OFFSET  (ir_q[10:0]),
        .CONTROL (ea_control),
        .EA      (ea)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_q, tmo_d;

    // Restarts on every entry to PTR/DATA; counts only while a request is held.
    always_comb begin
        tmo_d = '0;
        if ((state_q == StPtr || state_q == StData) && (state_d == state_q)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign timeout_hit = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) && !MEM_READY;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        rs1_d     = rs1_q;
        sr_d      = sr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        MEM_REQ   = 1'b0;
        MEM_WE    = 1'b0;
        DONE      = 1'b0;
        ERR       = 1'b0;
        REG_WE    = 1'b0;
        case (state_q)
            StIdle: begin
                if (START) begin
                    ir_d    = IR;
                    pc_d    = PC;
                    rs1_d   = RS1_DATA;
                    sr_d    = SR_DATA;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (!supported) begin
                    ERR     = 1'b1;
                    state_d = StIdle;
                end else begin
                    addr_d = ea;
                    if (is_lea) begin
                        state_d = StFin;
                    end else if (is_ind) begin
                        state_d = StPtr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StPtr: begin
                MEM_REQ = 1'b1;
                if (MEM_READY) begin
                    addr_d  = MEM_RDATA;
                    state_d = StData;
                end else if (timeout_hit) begin
                    ERR     = 1'b1;
                    state_d = StIdle;
                end
            end
            StData: begin
                MEM_REQ = 1'b1;
                MEM_WE  = is_store;
                if (MEM_READY) begin
                    if (is_load) begin
                        data_d = MEM_RDATA;
                    end
                    state_d = StFin;
                end else if (timeout_hit) begin
                    ERR     = 1'b1;
                    state_d = StIdle;
                end
            end
            StFin: begin
                DONE    = 1'b1;
                REG_WE  = is_load || is_lea;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign BUSY      = (state_q != StIdle);
    assign MEM_ADDR  = MEM_REQ ? addr_q : 16'h0000;
    assign MEM_WDATA = MEM_WE ? sr_q : 16'h0000;
    assign REG_DR    = REG_WE ? ir_q[11:9] : 3'b000;
    assign REG_DATA  = !REG_WE ? 16'h0000 : (is_lea ? addr_q : data_q);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            ir_q    <= '0;
            pc_q    <= '0;
            rs1_q   <= '0;
            sr_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            sr_q    <= sr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed self-checking bench for lsu_sequencer; a small memory responder lives in run_txn.
// Define LSU_TIMEOUT_EN to exercise the timeout path instead of the indefinite-wait path.

module tb_lsu_sequencer;
    logic        CLK = 1'b0;
    logic        RESET, START, MEM_READY;
    logic [15:0] IR, PC, RS1_DATA, SR_DATA, MEM_RDATA;
    logic        MEM_REQ, MEM_WE, BUSY, DONE, ERR, REG_WE;
    logic [15:0] MEM_ADDR, MEM_WDATA, REG_DATA;
    logic [2:0]  REG_DR;

    int n_cmp = 0;
    int n_fail = 0;

    // Results of the most recent run_txn call.
    int          r_lat, r_nreq, r_req_cycles, r_unstable;
    logic        r_done, r_err, r_reg_we, r_busy_after, r_req_after;
    logic [2:0]  r_reg_dr;
    logic [15:0] r_reg_data;
    logic [15:0] r_addr [2];
    logic        r_we [2];
    logic [15:0] r_wdata [2];

    lsu_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .IR        (IR),
        .PC        (PC),
        .RS1_DATA  (RS1_DATA),
        .SR_DATA   (SR_DATA),
        .MEM_REQ   (MEM_REQ),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RDATA (MEM_RDATA),
        .MEM_READY (MEM_READY),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .REG_WE    (REG_WE),
        .REG_DR    (REG_DR),
        .REG_DATA  (REG_DATA)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        case (a)
            16'h3006: mem_rd = 16'hBEEF;
            16'hFFFF: mem_rd = 16'h5000;
            16'h5000: mem_rd = 16'h0BAD;
            default:  mem_rd = 16'h0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Issues one instruction; READY rises on request cycle delay+1 (delay 0 = tied high).
    // r_lat counts edges from the START edge to the edge that samples DONE/ERR.
    task automatic run_txn(input logic [15:0] ir, pc, rs1, sr, input int delay, input int budget);
        int steps, rc;
        r_lat = -1; r_nreq = 0; r_req_cycles = 0; r_unstable = 0;
        r_done = 0; r_err = 0; r_reg_we = 0; r_reg_dr = 0; r_reg_data = 0;
        for (int i = 0; i < 2; i++) begin r_addr[i] = 0; r_we[i] = 0; r_wdata[i] = 0; end
        IR = ir; PC = pc; RS1_DATA = rs1; SR_DATA = sr;
        START = 1'b1; MEM_READY = (delay == 0);
        step();
        START = 1'b0; IR = 16'hFFFF; PC = 16'hFFFF; RS1_DATA = 16'hFFFF; SR_DATA = 16'hFFFF;
        steps = 0; rc = 0;
        while (steps < budget) begin
            if (MEM_REQ) begin
                rc++;
                r_req_cycles++;
                if (rc == 1 && r_nreq < 2) begin
                    r_addr[r_nreq] = MEM_ADDR; r_we[r_nreq] = MEM_WE; r_wdata[r_nreq] = MEM_WDATA;
                end else if (r_nreq < 2 && (MEM_ADDR !== r_addr[r_nreq] ||
                         MEM_WE !== r_we[r_nreq] || MEM_WDATA !== r_wdata[r_nreq])) begin
                    r_unstable++;
                end
                MEM_RDATA = mem_rd(MEM_ADDR);
                MEM_READY = (delay == 0) || (rc > delay);
                if (MEM_READY) begin r_nreq++; rc = 0; end
            end else begin
                MEM_READY = (delay == 0);
                MEM_RDATA = 16'hDEAD;
                rc = 0;
            end
            if (DONE) begin
                r_done = 1; r_lat = steps + 1;
                r_reg_we = REG_WE; r_reg_dr = REG_DR; r_reg_data = REG_DATA;
                break;
            end
            if (ERR) begin
                r_err = 1; r_lat = steps + 1;
                break;
            end
            step();
            steps++;
        end
        step();
        r_busy_after = BUSY;
        r_req_after = MEM_REQ;
        MEM_READY = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; START = 1'b1; MEM_READY = 1'b1; MEM_RDATA = 16'hFFFF;
        IR = 16'h2205; PC = 16'h3001; RS1_DATA = 0; SR_DATA = 0;
        step(); step();
        check("reset_busy", BUSY, 0);
        check("reset_outs", {MEM_REQ, MEM_WE, DONE, ERR, REG_WE}, 0);
        check("reset_data", {MEM_ADDR, MEM_WDATA, REG_DATA, 13'h0, REG_DR}, 0);
        RESET = 1'b0; START = 1'b0; MEM_READY = 1'b0;
        step();
        check("reset_idle", {BUSY, MEM_REQ}, 0);
    endtask

    task automatic test_ld();
        run_txn(16'h2205, 16'h3001, 16'h0000, 16'h0000, 0, 20);
        check("ld_done", r_done, 1);
        check("ld_lat", r_lat, 3);
        check("ld_addr", r_addr[0], 16'h3006);
        check("ld_we", r_we[0], 0);
        check("ld_nreq", r_nreq, 1);
        check("ld_wb", {r_reg_we, r_reg_dr, r_reg_data}, {1'b1, 3'd1, 16'hBEEF});
        check("ld_idle", r_busy_after, 0);
    endtask

    task automatic test_str();
        run_txn(16'h7A7F, 16'h0000, 16'h4000, 16'h1234, 0, 20);
        check("str_done", r_done, 1);
        check("str_lat", r_lat, 3);
        check("str_addr", r_addr[0], 16'h3FFF);
        check("str_we", r_we[0], 1);
        check("str_wdata", r_wdata[0], 16'h1234);
        check("str_reg_we", r_reg_we, 0);
    endtask

    task automatic test_ldi();
        run_txn(16'hA1FF, 16'h0000, 16'h0000, 16'h0000, 2, 30);
        check("ldi_done", r_done, 1);
        check("ldi_lat", r_lat, 8);
        check("ldi_ptr_addr", r_addr[0], 16'hFFFF);
        check("ldi_data_addr", r_addr[1], 16'h5000);
        check("ldi_we", {r_we[0], r_we[1]}, 0);
        check("ldi_nreq", r_nreq, 2);
        check("ldi_stable", r_unstable, 0);
        check("ldi_wb", {r_reg_we, r_reg_dr, r_reg_data}, {1'b1, 3'd0, 16'h0BAD});
    endtask

    task automatic test_lea();
        run_txn(16'hE0FE, 16'h3000, 16'h0000, 16'h0000, 0, 20);
        check("lea_done", r_done, 1);
        check("lea_lat", r_lat, 2);
        check("lea_nreq", r_req_cycles, 0);
        check("lea_wb", {r_reg_we, r_reg_dr, r_reg_data}, {1'b1, 3'd0, 16'h30FE});
    endtask

    task automatic test_illegal();
        run_txn(16'h1000, 16'h3000, 16'h0000, 16'h0000, 0, 20);
        check("ill_err", r_err, 1);
        check("ill_done", r_done, 0);
        check("ill_lat", r_lat, 1);
        check("ill_req", r_req_cycles, 0);
        check("ill_idle", r_busy_after, 0);
    endtask

    task automatic test_reset_mid();
        IR = 16'h7A7F; PC = 0; RS1_DATA = 16'h4000; SR_DATA = 16'h1234;
        START = 1'b1; MEM_READY = 1'b0;
        step();
        START = 1'b0;
        step();
        check("mid_in_data", {MEM_REQ, MEM_WE, MEM_ADDR}, {2'b11, 16'h3FFF});
        IR = 16'hE0FE; PC = 16'h1000; START = 1'b1;
        step();
        START = 1'b0;
        check("mid_start_ign", {BUSY, MEM_REQ, MEM_ADDR, MEM_WDATA}, {2'b11, 16'h3FFF, 16'h1234});
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("mid_reset", {BUSY, MEM_REQ, DONE, ERR, REG_WE}, 0);
        MEM_READY = 1'b1;
        step();
        check("mid_stay_idle", {BUSY, MEM_REQ, DONE, REG_WE}, 0);
        MEM_READY = 1'b0;
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        run_txn(16'h2205, 16'h3001, 16'h0000, 16'h0000, 1000, 40);
        check("tmo_err", r_err, 1);
        check("tmo_done", r_done, 0);
        check("tmo_req_cycles", r_req_cycles, 4);
        check("tmo_after", {r_busy_after, r_req_after}, 0);
    endtask
`else
    task automatic test_long_wait();
        run_txn(16'h2205, 16'h3001, 16'h0000, 16'h0000, 20, 60);
        check("wait_err", r_err, 0);
        check("wait_done", r_done, 1);
        check("wait_req_cycles", r_req_cycles, 21);
        check("wait_lat", r_lat, 23);
        check("wait_stable", r_unstable, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_ld();
        test_str();
        test_ldi();
        test_lea();
        test_illegal();
        test_reset_mid();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_ld();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_sequencer.md
LSU_SEQUENCER -- requirements
Module: lsu_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, MEM_READY wait limit in cycles (used only with LSU_TIMEOUT_EN).
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-high reset.
REQ-004 Port: START  input  1  begin one memory instruction; sampled only in IDLE.
REQ-005 Port: IR  input  16  instruction word; latched at START acceptance.
REQ-006 Port: PC  input  16  incremented PC; latched at START acceptance.
REQ-007 Port: RS1_DATA  input  16  base register value; latched at START acceptance.
REQ-008 Port: SR_DATA  input  16  store data; latched at START acceptance.
REQ-009 Port: MEM_REQ, MEM_WE  output  1 each  memory request and write strobe.
REQ-010 Port: MEM_ADDR, MEM_WDATA  output  16 each  memory address and write data.
REQ-011 Port: MEM_RDATA  input  16; MEM_READY  input  1  read data and request completion.
REQ-012 Port: BUSY  output  1  high in every state except IDLE.
REQ-013 Port: DONE, ERR  output  1 each  one-cycle completion and error pulses.
REQ-014 Port: REG_WE  output  1; REG_DR  output  3; REG_DATA  output  16  register-file writeback.

Function
REQ-015 Block SHALL instantiate effective_address, fed from latched IR/PC/RS1_DATA, and drive its 3-bit CONTROL.
REQ-016 CONTROL encoding SHALL be: LD/ST/LDI/STI/LEA 3'b010 (PC+PCoffset9); LDR/STR 3'b101 (RS1+offset6).
REQ-017 Supported opcodes IR[15:12]: LD 0010, ST 0011, LDR 0110, STR 0111, LDI 1010, STI 1011, LEA 1110.
REQ-018 States SHALL be IDLE, CALC, PTR, DATA, FIN.
REQ-019 IDLE + START: latch inputs, go to CALC. START outside IDLE SHALL be ignored.
REQ-020 CALC (one cycle): register EA into address register. Next state: FIN for LEA, PTR for LDI/STI, DATA otherwise.
REQ-021 Unsupported opcode in CALC: ERR pulse one cycle, no memory request, return to IDLE, no DONE.
REQ-022 PTR: MEM_REQ=1, MEM_WE=0 at address register. When MEM_READY=1, load MEM_RDATA into address register and go to DATA.
REQ-023 DATA: MEM_REQ=1, MEM_WE=1 for stores (MEM_WDATA=latched SR_DATA), 0 for loads. When MEM_READY=1, capture MEM_RDATA for loads and go to FIN.
REQ-024 MEM_ADDR, MEM_WE and MEM_WDATA SHALL stay stable while MEM_REQ=1. MEM_REQ SHALL drop in the cycle after MEM_READY is sampled.
REQ-025 MEM_READY while MEM_REQ=0 SHALL be ignored.
REQ-026 FIN (one cycle): DONE=1, then IDLE. Loads: REG_WE=1, REG_DATA=read data. LEA: REG_WE=1, REG_DATA=EA. Stores: REG_WE=0.
REQ-027 REG_DR SHALL equal latched IR[11:9] whenever REG_WE=1.
REQ-028 Addresses SHALL be computed modulo 2^16; x0000/xFFFF wrap with no flag.
REQ-029 Latency with MEM_READY high in the first request cycle, counted from the START edge: LEA 2, LD/ST/LDR/STR 3, LDI/STI 4 cycles to DONE.
REQ-030 MEM_REQ, MEM_WE, DONE, ERR and REG_WE SHALL be 0 in IDLE.

Reset
REQ-031 RESET=1 at an edge SHALL force IDLE and clear all registers and outputs to 0, overriding START and MEM_READY.
REQ-032 Reset mid-transaction SHALL deassert MEM_REQ at that edge with no DONE, ERR or REG_WE.

Configuration
REQ-033 With macro LSU_TIMEOUT_EN defined:
- a counter SHALL run in PTR and DATA and clear on entry to each;
- after TIMEOUT_CYCLES cycles without MEM_READY: drop MEM_REQ, pulse ERR, return to IDLE, no DONE.
REQ-034 Without LSU_TIMEOUT_EN: no counter; PTR/DATA SHALL wait for MEM_READY indefinitely.

Verification
REQ-035 LD: IR=0x2205, PC=0x3001, MEM_READY tied high, RDATA=0xBEEF -> MEM_ADDR=0x3006 with WE=0; DONE 3 cycles after START; REG_WE=1, REG_DR=1, REG_DATA=0xBEEF.
REQ-036 STR: IR=0x7A7F, RS1=0x4000, SR=0x1234 -> MEM_ADDR=0x3FFF, MEM_WE=1, MEM_WDATA=0x1234; REG_WE=0 at DONE.
REQ-037 LDI: IR=0xA1FF, PC=0x0000, READY delayed 2 cycles per request -> read at 0xFFFF returns 0x5000; second read at 0x5000; DONE 8 cycles after START.
REQ-038 LEA: IR=0xE0FE, PC=0x3000 -> no MEM_REQ; REG_DATA=0x30FE 2 cycles after START. Opcode 0x1 -> ERR pulse, no MEM_REQ.
REQ-039 RESET asserted mid-DATA, plus START pulsed while BUSY -> MEM_REQ=0 next cycle, no DONE, second START ignored.
REQ-040 With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, READY held low -> ERR after 4 request cycles, BUSY=0 next cycle.
